// File: rtl/ctrl_fsm_mc.sv
// Multi-cycle RV32I control FSM: decodes the instruction fields, sequences the
// datapath through IF/ID/EX/MEM/WB and traps on illegal encodings or stalled
// ALU / data-memory handshakes.
//
//   state | meaning
//   IF    | fetch; PC advances only in the IF right after a retire
//   ID    | decode, latch ALU/mux/memory controls
//   EX    | ALU running, wait for alu_valid
//   MEM   | data memory access, wait for dm_ready
//   WB    | register write strobe and retire pulse
//   TRAP  | illegal instruction or timeout, held until rst
module ctrl_fsm_mc #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 5,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic [2:0]          func3,
  input  logic [6:0]          func7,
  input  logic                alu_valid,
  input  logic                branch_taken,
  input  logic                dm_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_en,
  output logic [1:0]          port_a_sel,
  output logic                port_b_sel,
  output logic [2:0]          imm_sel,
  output logic                reg_read_en,
  output logic                reg_write_en,
  output logic [1:0]          write_mux_sel,
  output logic                pc_mux_sel,
  output logic                pc_stall,
  output logic                dm_read_en,
  output logic                dm_write_en,
  output logic [2:0]          load_store_op,
  output logic                retire,
  output logic                illegal_insn,
  output logic                timeout_err
);

  if (XLEN != 32 || TIMEOUT < 2) begin : g_param_chk
    $error("ctrl_fsm_mc: XLEN must be 32 and TIMEOUT at least 2");
  end

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(5'b00001);
  localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(5'b00011);
  localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(5'b01010);
  localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(5'b01100);
  localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(5'b01101);
  localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(5'b01110);
  localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(5'b01111);
  localparam logic [ALU_OP_W-1:0] OP_SRA  = ALU_OP_W'(5'b10000);
  localparam logic [ALU_OP_W-1:0] OP_SLT  = ALU_OP_W'(5'b10001);
  localparam logic [ALU_OP_W-1:0] OP_SLTU = ALU_OP_W'(5'b10010);
  localparam logic [ALU_OP_W-1:0] OP_ADDR = ALU_OP_W'(5'b11000);

  typedef enum logic [5:0] {
    S_IF   = 6'b000001,
    S_ID   = 6'b000010,
    S_EX   = 6'b000100,
    S_MEM  = 6'b001000,
    S_WB   = 6'b010000,
    S_TRAP = 6'b100000
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_LUI
  } cls_t;

  state_t                state;
  cls_t                  cls_q;
  logic [CNT_W-1:0]      wait_cnt;

  logic                  dec_ok;
  cls_t                  dec_cls;
  logic [ALU_OP_W-1:0]   dec_op;
  logic [1:0]            dec_a;
  logic                  dec_b;
  logic [2:0]            dec_imm;
  logic [2:0]            dec_ls;
  logic                  dec_rd;
  logic                  alt;

  // Instruction decode from the stable opcode/func fields
  always_comb begin
    dec_ok  = 1'b1;
    dec_cls = C_ALU;
    dec_op  = OP_ADD;
    dec_a   = 2'b01;
    dec_b   = 1'b0;
    dec_imm = 3'b000;
    dec_ls  = 3'b000;
    dec_rd  = 1'b1;
    alt     = (func7 == 7'b0100000);
    case (opcode)
      7'b0110011, 7'b0010011: begin
        if (opcode == 7'b0010011) begin
          dec_b   = 1'b1;
          dec_imm = 3'b001;
        end
        case (func3)
          3'b000: dec_op = (opcode == 7'b0110011 && alt) ? OP_SUB : OP_ADD;
          3'b001: dec_op = OP_SLL;
          3'b010: dec_op = OP_SLT;
          3'b011: dec_op = OP_SLTU;
          3'b100: dec_op = OP_XOR;
          3'b101: dec_op = alt ? OP_SRA : OP_SRL;
          3'b110: dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
        // R-type checks func7 for every func3; I-type only for shifts
        if (opcode == 7'b0110011 || func3 == 3'b001 || func3 == 3'b101) begin
          if (!(func7 == 7'b0000000 ||
                (alt && (func3 == 3'b101 || (func3 == 3'b000 && opcode == 7'b0110011)))))
            dec_ok = 1'b0;
        end
      end
      7'b0000011: begin
        dec_cls = C_LOAD;
        dec_op  = OP_ADDR;
        dec_b   = 1'b1;
        dec_imm = 3'b001;
        case (func3)
          3'b000:  dec_ls = 3'b100;
          3'b001:  dec_ls = 3'b101;
          3'b010:  dec_ls = 3'b000;
          3'b100:  dec_ls = 3'b110;
          3'b101:  dec_ls = 3'b111;
          default: dec_ok = 1'b0;
        endcase
      end
      7'b0100011: begin
        dec_cls = C_STORE;
        dec_op  = OP_ADDR;
        dec_b   = 1'b1;
        dec_imm = 3'b010;
        case (func3)
          3'b000:  dec_ls = 3'b001;
          3'b001:  dec_ls = 3'b010;
          3'b010:  dec_ls = 3'b011;
          default: dec_ok = 1'b0;
        endcase
      end
      7'b1100011: begin
        dec_cls = C_BRANCH;
        dec_a   = 2'b10;
        dec_b   = 1'b1;
        dec_imm = 3'b011;
        if (func3 == 3'b010 || func3 == 3'b011) dec_ok = 1'b0;
      end
      7'b1101111: begin
        dec_cls = C_JUMP;
        dec_a   = 2'b10;
        dec_b   = 1'b1;
        dec_imm = 3'b101;
        dec_rd  = 1'b0;
      end
      7'b1100111: begin
        dec_cls = C_JUMP;
        dec_b   = 1'b1;
        dec_imm = 3'b001;
        if (func3 != 3'b000) dec_ok = 1'b0;
      end
      7'b0010111: begin
        dec_a   = 2'b10;
        dec_b   = 1'b1;
        dec_imm = 3'b100;
        dec_rd  = 1'b0;
      end
      7'b0110111: begin
        dec_cls = C_LUI;
        dec_a   = 2'b00;
        dec_b   = 1'b1;
        dec_imm = 3'b100;
        dec_rd  = 1'b0;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // State sequencing with all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IF;
      cls_q         <= C_ALU;
      wait_cnt      <= '0;
      alu_op        <= '0;
      alu_en        <= 1'b0;
      port_a_sel    <= 2'b00;
      port_b_sel    <= 1'b0;
      imm_sel       <= 3'b000;
      reg_read_en   <= 1'b0;
      reg_write_en  <= 1'b0;
      write_mux_sel <= 2'b00;
      pc_mux_sel    <= 1'b0;
      pc_stall      <= 1'b1;
      dm_read_en    <= 1'b0;
      dm_write_en   <= 1'b0;
      load_store_op <= 3'b000;
      retire        <= 1'b0;
      illegal_insn  <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      case (state)
        S_IF: begin
          alu_en       <= 1'b0;
          dm_read_en   <= 1'b0;
          dm_write_en  <= 1'b0;
          reg_write_en <= 1'b0;
          reg_read_en  <= 1'b0;
          retire       <= 1'b0;
          pc_mux_sel   <= 1'b0;
          pc_stall     <= 1'b1;
          state        <= S_ID;
        end
        S_ID: begin
          if (!dec_ok) begin
            illegal_insn <= 1'b1;
            state        <= S_TRAP;
          end else begin
            alu_op        <= dec_op;
            port_a_sel    <= dec_a;
            port_b_sel    <= dec_b;
            imm_sel       <= dec_imm;
            load_store_op <= dec_ls;
            reg_read_en   <= dec_rd;
            cls_q         <= dec_cls;
            if (dec_cls == C_LUI) begin
              write_mux_sel <= 2'b11;
              reg_write_en  <= 1'b1;
              retire        <= 1'b1;
              state         <= S_WB;
            end else begin
              alu_en   <= 1'b1;
              wait_cnt <= CNT_LOAD;
              state    <= S_EX;
            end
          end
        end
        S_EX: begin
          if (alu_valid) begin
            alu_en <= 1'b0;
            case (cls_q)
              C_LOAD: begin
                dm_read_en <= 1'b1;
                wait_cnt   <= CNT_LOAD;
                state      <= S_MEM;
              end
              C_STORE: begin
                dm_write_en <= 1'b1;
                wait_cnt    <= CNT_LOAD;
                state       <= S_MEM;
              end
              C_BRANCH: begin
                pc_mux_sel <= branch_taken;
                retire     <= 1'b1;
                pc_stall   <= 1'b0;
                state      <= S_IF;
              end
              C_JUMP: begin
                write_mux_sel <= 2'b10;
                pc_mux_sel    <= 1'b1;
                reg_write_en  <= 1'b1;
                retire        <= 1'b1;
                state         <= S_WB;
              end
              default: begin
                write_mux_sel <= 2'b00;
                reg_write_en  <= 1'b1;
                retire        <= 1'b1;
                state         <= S_WB;
              end
            endcase
          end else if (wait_cnt == '0) begin
            alu_en      <= 1'b0;
            reg_read_en <= 1'b0;
            timeout_err <= 1'b1;
            state       <= S_TRAP;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        S_MEM: begin
          if (dm_ready) begin
            dm_read_en  <= 1'b0;
            dm_write_en <= 1'b0;
            retire      <= 1'b1;
            if (cls_q == C_LOAD) begin
              write_mux_sel <= 2'b01;
              reg_write_en  <= 1'b1;
              state         <= S_WB;
            end else begin
              pc_stall <= 1'b0;
              state    <= S_IF;
            end
          end else if (wait_cnt == '0) begin
            dm_read_en  <= 1'b0;
            dm_write_en <= 1'b0;
            reg_read_en <= 1'b0;
            timeout_err <= 1'b1;
            state       <= S_TRAP;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        S_WB: begin
          reg_write_en <= 1'b0;
          retire       <= 1'b0;
          pc_stall     <= 1'b0;
          state        <= S_IF;
        end
        default: begin
          alu_en       <= 1'b0;
          reg_read_en  <= 1'b0;
          reg_write_en <= 1'b0;
          dm_read_en   <= 1'b0;
          dm_write_en  <= 1'b0;
          retire       <= 1'b0;
          pc_stall     <= 1'b1;
          state        <= S_TRAP;
        end
      endcase
    end
  end

endmodule
